// File: rtl/led_ti_pkg.sv
// rtl/led_ti_pkg.sv - shared widths and mask type for the TI masking datapath
package led_ti_pkg;

   localparam int MASK_W    = 64;
   localparam int NIB_W     = 4;
   localparam int NIB_CNT_W = 4;

   typedef logic [MASK_W-1:0] mask_t;

endpackage

// File: rtl/mask_fifo.sv
// rtl/mask_fifo.sv - small mask-word FIFO with flush, fill level and head output
module mask_fifo
   import led_ti_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  mask_t                  din,
   output mask_t                  head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] DEPTH_L = FILL_W'(DEPTH);

   mask_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_pop;
   logic              do_push;

   // A push into a full FIFO is legal only when the head leaves on the same edge.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < DEPTH_L) || do_pop);
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy; flush and reset both return to the empty, zeroed state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rand_mask_buffer.sv
// rtl/rand_mask_buffer.sv - packs LFSR nibbles into mask words, buffers them, guards source health
module rand_mask_buffer
   import led_ti_pkg::*;
#(
   parameter int NIB_PER_WORD = 16,
   parameter int DEPTH        = 2,
   parameter int STUCK_LIMIT  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NIB_W-1:0]       rnd_in,
   input  logic                   rnd_valid,
   input  logic                   flush,
   output mask_t                  mask_out,
   output logic                   mask_valid,
   input  logic                   mask_ready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   health_err
);

   localparam int FILL_W = $clog2(DEPTH) + 1;
   localparam int RUN_W  = $clog2(STUCK_LIMIT + 1);
   localparam logic [NIB_CNT_W-1:0] LAST_NIB = NIB_CNT_W'(NIB_PER_WORD - 1);
   localparam logic [FILL_W-1:0]    DEPTH_L  = FILL_W'(DEPTH);
   localparam logic [RUN_W-1:0]     LIMIT_L  = RUN_W'(STUCK_LIMIT);

   logic [NIB_CNT_W-1:0] pack_cnt;
   mask_t                pack_reg;
   mask_t                word_next;
   logic [NIB_W-1:0]     last_nib;
   logic [RUN_W-1:0]     run_cnt;
   logic [RUN_W-1:0]     run_next;
   logic                 at_last;
   logic                 space;
   logic                 pop;
   logic                 accept;
   logic                 push;
   logic                 trip;

   // Health errors hide the buffered words from the consumer immediately.
   assign mask_valid = (fill_level != '0) && !health_err;
   assign pop        = mask_valid && mask_ready;
   assign at_last    = (pack_cnt == LAST_NIB);
   // A word can only complete if the FIFO has room now or frees a slot on this edge.
   assign space      = (fill_level < DEPTH_L) || pop;
   assign accept     = rnd_valid && !health_err && !flush && (!at_last || space);
   assign push       = accept && at_last;
   assign trip       = accept && ((rnd_in == '0) || (run_next >= LIMIT_L));

   // Current word with the incoming nibble dropped into its slot; this is what gets pushed.
   always_comb begin
      word_next = pack_reg;
      word_next[{pack_cnt, 2'b00} +: NIB_W] = rnd_in;
   end

   // Length of the identical-nibble run if rnd_in is accepted; zero run_cnt means no history.
   always_comb begin
      run_next = RUN_W'(1);
      if ((run_cnt != '0) && (rnd_in == last_nib)) begin
         run_next = run_cnt + 1'b1;
      end
   end

   // Packer: collects accepted nibbles, restarts after each pushed word or on flush/health error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_cnt <= '0;
         pack_reg <= '0;
      end else if (flush || health_err) begin
         pack_cnt <= '0;
         pack_reg <= '0;
      end else if (accept) begin
         if (at_last) begin
            pack_cnt <= '0;
            pack_reg <= '0;
         end else begin
            pack_cnt <= pack_cnt + 1'b1;
            pack_reg <= word_next;
         end
      end
   end

   // Health monitor: sticky error on a lock-up nibble or an over-long repeat run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt    <= '0;
         last_nib   <= '0;
         health_err <= 1'b0;
      end else if (flush) begin
         run_cnt    <= '0;
         last_nib   <= '0;
         health_err <= 1'b0;
      end else if (accept) begin
         run_cnt  <= run_next;
         last_nib <= rnd_in;
         if (trip) begin
            health_err <= 1'b1;
         end
      end
   end

   mask_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush || health_err),
      .din   (word_next),
      .head  (mask_out),
      .count (fill_level)
   );

endmodule

// File: tb/tb_rand_mask_buffer.sv
// tb/tb_rand_mask_buffer.sv - directed and random scoreboard bench for rand_mask_buffer
module tb_rand_mask_buffer;
   import led_ti_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rnd_in;
   logic        rnd_valid;
   logic        flush;
   mask_t       mask_out;
   logic        mask_valid;
   logic        mask_ready;
   logic [1:0]  fill_level;
   logic        health_err;

   int          passed = 0;
   int          total  = 0;

   mask_t       q[$];
   int          m_cnt;
   mask_t       m_word;
   int          m_run;
   logic [3:0]  m_last;
   logic        m_err;

   rand_mask_buffer #(
      .NIB_PER_WORD (16),
      .DEPTH        (2),
      .STUCK_LIMIT  (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rnd_in     (rnd_in),
      .rnd_valid  (rnd_valid),
      .flush      (flush),
      .mask_out   (mask_out),
      .mask_valid (mask_valid),
      .mask_ready (mask_ready),
      .fill_level (fill_level),
      .health_err (health_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic model_clear();
      q.delete();
      m_cnt  = 0;
      m_word = '0;
      m_run  = 0;
      m_last = '0;
      m_err  = 1'b0;
   endtask

   // One clock: compare outputs against the model, advance the model across the edge.
   task automatic tick();
      logic m_valid, do_pop, space, acc, err_prev;
      m_valid = (q.size() != 0) && !m_err;
      chk("mask_valid", 64'(mask_valid), 64'(m_valid));
      chk("fill_level", 64'(fill_level), 64'(q.size()));
      chk("health_err", 64'(health_err), 64'(m_err));
      if (m_valid) chk("mask_out", mask_out, q[0]);
      do_pop   = m_valid && mask_ready;
      space    = (q.size() < 2) || do_pop;
      acc      = rnd_valid && !m_err && !flush && ((m_cnt != 15) || space);
      err_prev = m_err;
      @(posedge clk);
      if (flush) begin
         model_clear();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (err_prev) begin
            q.delete();
            m_cnt  = 0;
            m_word = '0;
         end else if (acc) begin
            m_word[m_cnt*4 +: 4] = rnd_in;
            if ((m_run == 0) || (rnd_in != m_last)) m_run = 1;
            else m_run++;
            m_last = rnd_in;
            if ((rnd_in == 4'h0) || (m_run >= 8)) m_err = 1'b1;
            if (m_cnt == 15) begin
               q.push_back(m_word);
               m_word = '0;
               m_cnt  = 0;
            end else begin
               m_cnt++;
            end
         end
      end
      #1;
   endtask

   task automatic do_flush();
      flush     = 1'b1;
      rnd_valid = 1'b0;
      tick();
      flush     = 1'b0;
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         rnd_in    = 4'((i % 15) + 1);
         rnd_valid = 1'b1;
         tick();
      end
      rnd_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] prev_nib;
      rst_n      = 1'b0;
      rnd_in     = '0;
      rnd_valid  = 1'b0;
      flush      = 1'b0;
      mask_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst mask_valid", 64'(mask_valid), 64'd0);
      chk("rst fill_level", 64'(fill_level), 64'd0);
      chk("rst health_err", 64'(health_err), 64'd0);
      chk("rst mask_out", mask_out, 64'd0);
      rst_n = 1'b1;

      // First word: nibbles 1..F,1
      stream(15);
      chk("pre16 mask_valid", 64'(mask_valid), 64'd0);
      rnd_in = 4'h1; rnd_valid = 1'b1; tick(); rnd_valid = 1'b0;
      chk("word1 valid", 64'(mask_valid), 64'd1);
      chk("word1 value", mask_out, 64'h1FEDCBA987654321);
      chk("word1 fill", 64'(fill_level), 64'd1);

      // Fill to full, stall at count 15, then pop and push on one edge
      do_flush();
      stream(48);
      chk("stall fill", 64'(fill_level), 64'd2);
      chk("stall head", mask_out, 64'h1FEDCBA987654321);
      mask_ready = 1'b1; rnd_in = 4'h4; rnd_valid = 1'b1;
      tick();
      mask_ready = 1'b0; rnd_valid = 1'b0;
      chk("push+pop fill", 64'(fill_level), 64'd2);
      chk("word2 value", mask_out, 64'h21FEDCBA98765432);
      mask_ready = 1'b1;
      repeat (3) tick();
      mask_ready = 1'b0;

      // Stuck-run detection
      do_flush();
      stream(16);
      for (int i = 0; i < 7; i++) begin
         rnd_in = 4'h5; rnd_valid = 1'b1; tick();
      end
      chk("run7 health", 64'(health_err), 64'd0);
      tick();
      rnd_valid = 1'b0;
      chk("run8 health", 64'(health_err), 64'd1);
      chk("run8 valid", 64'(mask_valid), 64'd0);
      chk("run8 fill", 64'(fill_level), 64'd1);
      tick();
      chk("run8 cleared", 64'(fill_level), 64'd0);

      // Lock-up nibble, flush recovery, fresh word
      do_flush();
      chk("flush health", 64'(health_err), 64'd0);
      chk("flush fill", 64'(fill_level), 64'd0);
      stream(5);
      rnd_in = 4'h0; rnd_valid = 1'b1; tick(); rnd_valid = 1'b0;
      chk("zero health", 64'(health_err), 64'd1);
      do_flush();
      chk("reflush health", 64'(health_err), 64'd0);
      stream(15);
      chk("restart pre16", 64'(mask_valid), 64'd0);
      rnd_in = 4'h1; rnd_valid = 1'b1; tick(); rnd_valid = 1'b0;
      chk("restart valid", 64'(mask_valid), 64'd1);
      mask_ready = 1'b1; tick(); mask_ready = 1'b0;

      // Asynchronous reset between edges
      do_flush();
      stream(16);
      stream(7);
      chk("pre-reset fill", 64'(fill_level), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async valid", 64'(mask_valid), 64'd0);
      chk("async fill", 64'(fill_level), 64'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stream(15);
      chk("post-reset pre16", 64'(mask_valid), 64'd0);
      rnd_in = 4'h1; rnd_valid = 1'b1; tick(); rnd_valid = 1'b0;
      chk("post-reset word", mask_out, 64'h1FEDCBA987654321);

      // Random handshake traffic checked by the scoreboard
      prev_nib = 4'h1;
      for (int i = 0; i < 600; i++) begin
         logic [3:0] n;
         n = 4'($urandom_range(1, 15));
         if (n == prev_nib) n = (n == 4'hF) ? 4'h1 : n + 4'h1;
         prev_nib   = n;
         rnd_in     = n;
         rnd_valid  = 1'($urandom_range(0, 1));
         mask_ready = ($urandom_range(0, 3) == 0);
         tick();
      end
      rnd_valid  = 1'b0;
      mask_ready = 1'b1;
      repeat (6) tick();
      chk("drain fill", 64'(fill_level), 64'd0);
      chk("drain scoreboard", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
